fadd_arbiter: RTL and testbench

- Shares one pipelined FP16 adder among N requesters.
- Each cycle, picks at most one valid requester round-robin and issues its operand pair to the adder.
- Tracks in-flight operations with a LAT-deep tag pipeline and routes each sum back to its originating requester.
- Sits between the vector/accumulator clients and the single FP16 adder instance.

---
 rtl/fadd_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/fadd_arbiter.sv | 115 +++++++++++
 tb/tb_fadd_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fadd_pkg.sv
// fadd_pkg: FP16 format constants and shared helpers for the adder arbiter
package fadd_pkg;
    localparam int BITS = 16;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int EXP_BIAS = 15;
    localparam logic [BITS-1:0] POS_ONE = 16'h3C00;
    localparam logic [BITS-1:0] POS_ZERO = 16'h0000;

    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int k = 1; k < 31; k++) r = ((1 << k) < v) ? k + 1 : r;
        return r;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: grants the first eligible requester at or after ptr, wrapping
module rr_arbiter
    import fadd_pkg::*;
#(
    parameter int N = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   i_eligible,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);
    // scan from the farthest candidate back toward ptr so the nearest eligible one wins
    always_comb begin
        int j;
        j = 0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(i_ptr) + k) % N;
            o_idx = i_eligible[j[IDW-1:0]] ? j[IDW-1:0] : o_idx;
            o_any = o_any | i_eligible[j[IDW-1:0]];
        end
        o_grant = o_any ? N'(1) << o_idx : '0;
    end
endmodule

// File: rtl/fadd_arbiter.sv
// fadd_arbiter: shares one pipelined FP16 adder among N requesters and routes sums back
module fadd_arbiter
    import fadd_pkg::*;
#(
    parameter int N = 4,
    parameter int BITS = 16,
    parameter int LAT = 3,
    parameter int MAX_OUT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req_valid,
    output logic [N-1:0]            req_ready,
    input  logic [N*BITS-1:0]       req_a,
    input  logic [N*BITS-1:0]       req_b,
    output logic                    add_valid,
    output logic [BITS-1:0]         add_a,
    output logic [BITS-1:0]         add_b,
    input  logic [BITS-1:0]         add_sum,
    output logic [N-1:0]            rsp_valid,
    output logic [BITS-1:0]         rsp_sum,
    output logic [clog2(N)-1:0]     rsp_id
);
    localparam int IDW = clog2(N);

    logic [N-1:0]    w_elig;
    logic [N-1:0]    w_grant;
    logic [IDW-1:0]  w_gidx;
    logic            w_any;
    logic [BITS-1:0] w_a;
    logic [BITS-1:0] w_b;
    logic [IDW-1:0]  r_ptr;
    logic [2:0]      r_cnt [N];
    logic [LAT:0]    r_tv;
    logic [IDW-1:0]  r_tid [LAT+1];
    logic [BITS-1:0] r_add_a;
    logic [BITS-1:0] r_add_b;
    logic [N-1:0]    r_rsp_valid;
    logic [BITS-1:0] r_rsp_sum;
    logic [IDW-1:0]  r_rsp_id;

    // a requester competes only while it has credit left
    always_comb begin
        w_elig = '0;
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N; i++) begin
            w_elig[i] = req_valid[i] && (r_cnt[i] < 3'(MAX_OUT));
            w_a = w_grant[i] ? req_a[i*BITS +: BITS] : w_a;
            w_b = w_grant[i] ? req_b[i*BITS +: BITS] : w_b;
        end
    end

    rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
        .i_eligible (w_elig),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_idx      (w_gidx),
        .o_any      (w_any)
    );

    assign req_ready = rst ? '0 : w_grant;
    assign add_valid = r_tv[0];
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_id    = r_rsp_id;

    // issue register, rr pointer and tag valid pipe; stage 0 travels with add_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tv    <= '0;
            r_add_a <= '0;
            r_add_b <= '0;
            r_ptr   <= '0;
        end else begin
            r_tv <= {r_tv[LAT-1:0], w_any};
            if (w_any) begin
                r_add_a <= w_a;
                r_add_b <= w_b;
                r_ptr   <= (int'(w_gidx) == N - 1) ? '0 : w_gidx + 1'b1;
            end
        end
    end

    // tag ids need no reset: they are only looked at alongside a valid bit
    always_ff @(posedge clk) begin
        r_tid[0] <= w_gidx;
        for (int k = 1; k <= LAT; k++) r_tid[k] <= r_tid[k-1];
    end

    // the last tag stage lines up with add_sum; register it as the response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_sum   <= '0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= r_tv[LAT] ? N'(1) << r_tid[LAT] : '0;
            if (r_tv[LAT]) begin
                r_rsp_sum <= add_sum;
                r_rsp_id  <= r_tid[LAT];
            end
        end
    end

    // outstanding credit per requester: up on grant, down when its tag retires
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) r_cnt[i] <= '0;
            else r_cnt[i] <= r_cnt[i] + 3'(w_grant[i]) - 3'(r_tv[LAT] && (r_tid[LAT] == IDW'(i)));
        end
    end
endmodule

// File: tb/tb_fadd_arbiter.sv
// tb_fadd_arbiter: vector tables, directed sequences and random traffic against a queue model
module tb_fadd_arbiter;
    localparam int N = 4;
    localparam int BITS = 16;
    localparam int LAT = 3;
    localparam int MAX_OUT = 2;
    localparam int IDW = 2;

    typedef struct {
        int             due;
        logic [BITS-1:0] sum;
    } exp_t;

    typedef struct {
        logic [N-1:0]    v;
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [N-1:0]    rdy;
        logic [N-1:0]    rsp;
        logic [BITS-1:0] sum;
    } vec_t;

    logic                clk;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*BITS-1:0]   req_a;
    logic [N*BITS-1:0]   req_b;
    logic                add_valid;
    logic [BITS-1:0]     add_a;
    logic [BITS-1:0]     add_b;
    logic [BITS-1:0]     add_sum;
    logic [N-1:0]        rsp_valid;
    logic [BITS-1:0]     rsp_sum;
    logic [IDW-1:0]      rsp_id;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mptr = 0;
    exp_t q [N][$];
    logic [N-1:0]    drv_v;
    logic [BITS-1:0] drv_a [N];
    logic [BITS-1:0] drv_b [N];
    logic            iss_v;
    logic [BITS-1:0] iss_a;
    logic [BITS-1:0] iss_b;
    logic [N-1:0]    last_rdy;
    logic [N-1:0]    last_rsp;
    logic [BITS-1:0] last_sum;
    logic [IDW-1:0]  last_id;
    logic [BITS-1:0] apipe [LAT];
    vec_t tbl [18];
    int got [$];

    fadd_arbiter #(.N(N), .BITS(BITS), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_valid (add_valid),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // small-integer FP16 values keep sums exact
    function automatic int dec(input logic [15:0] x);
        if (x[14:10] == 5'd0) return 0;
        return (1024 + int'(x[9:0])) >> (25 - int'(x[14:10]));
    endfunction

    function automatic logic [15:0] enc(input int v);
        int e;
        e = 0;
        if (v == 0) return 16'h0000;
        for (int k = 0; k < 16; k++) if ((v >> k) != 0) e = k;
        return {1'b0, 5'(e + 15), 10'((v << (10 - e)) & 1023)};
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        return enc(dec(a) + dec(b));
    endfunction

    // adder model: fixed latency, poisoned output when nothing was issued
    always @(posedge clk) begin
        apipe[0] <= add_valid ? fadd(add_a, add_b) : 16'h7E00;
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign add_sum = apipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // one clock: drive, sample mid-cycle, check against the model, advance
    task automatic step();
        logic [N-1:0] exp_rv;
        logic [N-1:0] exp_rdy;
        int g;
        int j;
        exp_t e;
        req_valid = drv_v;
        for (int i = 0; i < N; i++) begin
            req_a[i*BITS +: BITS] = drv_a[i];
            req_b[i*BITS +: BITS] = drv_b[i];
        end
        #3;
        chk("add_valid", 32'(add_valid), 32'(iss_v));
        if (iss_v) begin
            chk("add_a", 32'(add_a), 32'(iss_a));
            chk("add_b", 32'(add_b), 32'(iss_b));
        end
        exp_rv = '0;
        for (int i = 0; i < N; i++) if (q[i].size() > 0 && q[i][0].due == cyc) exp_rv[i] = 1'b1;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        for (int i = 0; i < N; i++) begin
            if (exp_rv[i]) begin
                chk("rsp_sum", 32'(rsp_sum), 32'(q[i][0].sum));
                chk("rsp_id", 32'(rsp_id), i);
            end
            while (q[i].size() > 0 && q[i][0].due <= cyc) void'(q[i].pop_front());
            chk("credit_cnt", 32'(dut.r_cnt[i]), q[i].size());
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
            j = (mptr + k) % N;
            if (g < 0 && drv_v[j] && q[j].size() < MAX_OUT) g = j;
        end
        exp_rdy = (g >= 0) ? N'(1) << g : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        iss_v = (g >= 0);
        if (g >= 0) begin
            iss_a = drv_a[g];
            iss_b = drv_b[g];
            e.due = cyc + LAT + 2;
            e.sum = fadd(drv_a[g], drv_b[g]);
            q[g].push_back(e);
            mptr = (g + 1) % N;
        end
        last_rdy = req_ready;
        last_rsp = rsp_valid;
        last_sum = rsp_sum;
        last_id = rsp_id;
        if (last_rsp != 0) got.push_back(int'(last_id));
        drv_v = drv_v & ~req_ready;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req_valid = drv_v;
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_add_valid", 32'(add_valid), 0);
        chk("rst_add_a", 32'(add_a), 0);
        chk("rst_add_b", 32'(add_b), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_sum", 32'(rsp_sum), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        mptr = 0;
        iss_v = 1'b0;
        got.delete();
    endtask

    task automatic drain(input int n);
        repeat (n) step();
    endtask

    initial begin
        int total;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        drv_v = '0;
        iss_v = 1'b0;
        iss_a = '0;
        iss_b = '0;
        for (int i = 0; i < N; i++) begin
            drv_a[i] = '0;
            drv_b[i] = '0;
        end
        for (int k = 0; k < 18; k++) tbl[k] = '{4'b0, 16'h0, 16'h0, 4'b0, 4'b0, 16'h0};
        tbl[0]  = '{4'b0001, 16'h3C00, 16'h4000, 4'b0001, 4'b0000, 16'h0000};
        tbl[5]  = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'b0001, 16'h4200};
        tbl[6]  = '{4'b0010, 16'h3C00, 16'h3C00, 4'b0010, 4'b0000, 16'h0000};
        tbl[10] = '{4'b0010, 16'h4000, 16'h4000, 4'b0010, 4'b0000, 16'h0000};
        tbl[11] = '{4'b0010, 16'h4200, 16'h4200, 4'b0010, 4'b0010, 16'h4000};
        tbl[15] = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'b0010, 16'h4400};
        tbl[16] = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'b0010, 16'h4600};
        #1;
        do_reset(2);

        // single request, then grant and retire colliding on requester 1
        for (int k = 0; k < 18; k++) begin
            drv_v = tbl[k].v;
            for (int i = 0; i < N; i++) begin
                drv_a[i] = tbl[k].a;
                drv_b[i] = tbl[k].b;
            end
            step();
            chk("vec_ready", 32'(last_rdy), 32'(tbl[k].rdy));
            chk("vec_rsp", 32'(last_rsp), 32'(tbl[k].rsp));
            if (tbl[k].rsp != 0) chk("vec_sum", 32'(last_sum), 32'(tbl[k].sum));
        end

        // all requesters busy from reset: strict rotation out and back
        do_reset(1);
        for (int i = 0; i < N; i++) begin
            drv_a[i] = enc(i + 1);
            drv_b[i] = enc(2 * i);
        end
        for (int k = 0; k < 8; k++) begin
            drv_v = '1;
            step();
            chk("rot_grant", 32'(last_rdy), 32'(N'(1) << (k % N)));
        end
        drain(20);
        chk("rot_rsp_count", got.size(), 11);
        for (int j = 0; j < got.size(); j++) chk("rot_rsp_order", got[j], j % N);

        // one requester hammering: credit limit paces it to 2 per LAT+2
        do_reset(1);
        drv_a[2] = enc(5);
        drv_b[2] = enc(7);
        for (int k = 0; k < 15; k++) begin
            drv_v = 4'b0100;
            step();
            chk("credit_ready", 32'(last_rdy[2]), 32'((k % (LAT + 2)) < MAX_OUT));
        end
        drain(10);

        // reset with three ops in flight drops them all
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            drv_v = '1;
            step();
        end
        drv_v = '1;
        do_reset(2);
        for (int k = 0; k < LAT + 2; k++) begin
            drv_v = '1;
            step();
            if (k == 0) chk("post_rst_grant", 32'(last_rdy), 1);
            chk("post_rst_no_rsp", 32'(last_rsp), 0);
        end
        drain(20);

        // random traffic against the scoreboard
        do_reset(1);
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!drv_v[i] && $urandom_range(1, 0) == 1) begin
                    drv_a[i] = enc(int'($urandom_range(15, 0)));
                    drv_b[i] = enc(int'($urandom_range(15, 0)));
                    drv_v[i] = 1'b1;
                end
            end
            step();
        end
        drain(30);
        total = 0;
        for (int i = 0; i < N; i++) total += q[i].size();
        chk("drained", total, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
